// File: rtl/uart_pkg.sv
// Shared UART configuration types.
//   baud_sel_t  : 2-bit baud-select code seen by the Tx/Rx baud generators
//   ab_state_t  : state encoding of the auto-baud controller
//   bit_period(): bit period in system-clock cycles for a given baud rate
package uart_pkg;

  typedef enum logic [1:0] {
    BRD4800   = 2'b00,
    BRD9600   = 2'b01,
    BRD57600  = 2'b10,
    BRD115200 = 2'b11
  } baud_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_FALL,
    ST_MEASURE,
    ST_APPLY
  } ab_state_t;

  // Integer division truncates, which matches how the generators divide.
  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous signals into the
// clk domain.
//   clk   : destination clock
//   rst   : asynchronous active-high reset, loads RESET_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronised output, two clk cycles behind d_i
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud / manual baud configuration controller for the UART baud
// generators. Measures the start-bit width of a sync character (first low
// pulse on rx) or takes a manual code, then applies the new select code while
// holding the generators in reset for RST_CYCLES cycles.
//   clk        : system clock (CLK_FREQ Hz)
//   rst        : asynchronous active-high reset
//   rx_i       : raw serial line, asynchronous, idle high
//   start_i    : pulse, begins auto-baud detection
//   cfg_wr_i   : pulse, manual select write (priority over start_i)
//   cfg_sel_i  : manual select code, valid with cfg_wr_i
//   sel_baud_o : select code to the generators (00=4800 .. 11=115200)
//   baud_rst_o : synchronous reset to the generators during a rate change
//   busy_o     : high whenever the controller is not idle
//   locked_o   : high once a rate has been applied
//   err_o      : sticky detection failure, cleared by start_i or cfg_wr_i
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 10_000_000,
  parameter logic [1:0]  DEFAULT_SEL = 2'b01,
  parameter int unsigned RST_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       start_i,
  input  logic       cfg_wr_i,
  input  logic [1:0] cfg_sel_i,
  output logic [1:0] sel_baud_o,
  output logic       baud_rst_o,
  output logic       busy_o,
  output logic       locked_o,
  output logic       err_o
);

  // Bit periods and classification thresholds, all in clk cycles.
  localparam int unsigned P4800   = bit_period(CLK_FREQ, 4800);
  localparam int unsigned P9600   = bit_period(CLK_FREQ, 9600);
  localparam int unsigned P57600  = bit_period(CLK_FREQ, 57600);
  localparam int unsigned P115200 = bit_period(CLK_FREQ, 115200);

  localparam int unsigned T0   = (P4800 + P9600) / 2;
  localparam int unsigned T1   = (P9600 + P57600) / 2;
  localparam int unsigned T2   = (P57600 + P115200) / 2;
  localparam int unsigned NMIN = P115200 / 2;
  localparam int unsigned NMAX = 2 * P4800;

  localparam int unsigned CNT_W = $clog2(NMAX + 1);

  localparam logic [CNT_W-1:0] T0_C   = CNT_W'(T0);
  localparam logic [CNT_W-1:0] T1_C   = CNT_W'(T1);
  localparam logic [CNT_W-1:0] T2_C   = CNT_W'(T2);
  localparam logic [CNT_W-1:0] NMIN_C = CNT_W'(NMIN);
  localparam logic [CNT_W-1:0] NMAX_C = CNT_W'(NMAX);

  // RST_CYCLES is limited to 1..15 so it fits the 4-bit apply counter.
  localparam logic [3:0] RST_C = 4'(RST_CYCLES);

  ab_state_t        state_q;
  baud_sel_t        sel_q;
  logic             baud_rst_q;
  logic             busy_q;
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] n_q;
  logic [3:0]       apply_cnt_q;

  logic             rx_s;
  logic [CNT_W-1:0] n_d;
  baud_sel_t        class_d;
  baud_sel_t        pend_d;
  logic             too_short_d;
  logic             timeout_d;
  logic             go_apply_d;
  logic             fail_d;

  // rx idles high, so the synchroniser resets to 1 to avoid a fake falling
  // edge right after reset.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (rx_s)
  );

  assign n_d         = n_q + CNT_W'(1);
  assign too_short_d = (n_q < NMIN_C);
  // Timeout fires on the cycle N would reach NMAX with the line still low.
  assign timeout_d   = (n_d >= NMAX_C);

  // Longer low pulse means slower rate; thresholds sit midway between the
  // nominal bit periods.
  always_comb begin
    if (n_q >= T0_C) begin
      class_d = BRD4800;
    end else if (n_q >= T1_C) begin
      class_d = BRD9600;
    end else if (n_q >= T2_C) begin
      class_d = BRD57600;
    end else begin
      class_d = BRD115200;
    end
  end

  // A manual write always wins over a measured result in the same cycle.
  assign pend_d = cfg_wr_i ? baud_sel_t'(cfg_sel_i) : class_d;

  // Decide when to enter APPLY or abandon detection. APPLY itself ignores
  // both host requests so a change in progress is never cut short.
  always_comb begin
    go_apply_d = 1'b0;
    fail_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ARM, ST_WAIT_FALL: begin
        go_apply_d = cfg_wr_i;
      end
      ST_MEASURE: begin
        if (cfg_wr_i) begin
          go_apply_d = 1'b1;
        end else if (rx_s) begin
          if (too_short_d) begin
            fail_d = 1'b1;
          end else begin
            go_apply_d = 1'b1;
          end
        end else if (timeout_d) begin
          fail_d = 1'b1;
        end
      end
      default: begin
        go_apply_d = 1'b0;
        fail_d     = 1'b0;
      end
    endcase
  end

  // Main FSM with registered outputs. On APPLY entry the new code, baud_rst
  // and the locked drop all land on the same edge, so the generators never
  // run on the new code outside of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= baud_sel_t'(DEFAULT_SEL);
      baud_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      n_q         <= '0;
      apply_cnt_q <= '0;
    end else if (go_apply_d) begin
      state_q     <= ST_APPLY;
      sel_q       <= pend_d;
      baud_rst_q  <= 1'b1;
      busy_q      <= 1'b1;
      locked_q    <= 1'b0;
      apply_cnt_q <= 4'd1;
      if (cfg_wr_i) begin
        err_q <= 1'b0;
      end
    end else if (fail_d) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q  <= ST_ARM;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            n_q      <= '0;
          end
        end
        ST_ARM: begin
          if (rx_s) begin
            state_q <= ST_WAIT_FALL;
          end
        end
        ST_WAIT_FALL: begin
          if (!rx_s) begin
            n_q     <= CNT_W'(1);
            state_q <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          n_q <= n_d;
        end
        ST_APPLY: begin
          // apply_cnt_q counts the cycles baud_rst has already been high.
          if (baud_rst_q) begin
            if (apply_cnt_q == RST_C) begin
              baud_rst_q <= 1'b0;
            end else begin
              apply_cnt_q <= apply_cnt_q + 4'd1;
            end
          end else begin
            locked_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          baud_rst_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel_baud_o = sel_q;
  assign baud_rst_o = baud_rst_q;
  assign busy_o     = busy_q;
  assign locked_o   = locked_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl at 10 MHz: directed and random
// start-bit widths, boundary widths around every threshold, glitch, timeout,
// manual abort, start/cfg_wr collisions and reset in the middle of APPLY.
module tb_uart_autobaud_ctrl;

  localparam int unsigned CLK_FREQ   = 10_000_000;
  localparam int unsigned RST_CYCLES = 4;

  logic       clk;
  logic       rst;
  logic       rxLine;
  logic       startPulse;
  logic       cfgWr;
  logic [1:0] cfgSel;
  logic [1:0] selBaud;
  logic       baudRst;
  logic       busy;
  logic       locked;
  logic       err;

  int         assertCount;
  int         failCount;
  logic [1:0] modelSel;

  uart_autobaud_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .DEFAULT_SEL (2'b01),
    .RST_CYCLES  (RST_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rxLine),
    .start_i    (startPulse),
    .cfg_wr_i   (cfgWr),
    .cfg_sel_i  (cfgSel),
    .sel_baud_o (selBaud),
    .baud_rst_o (baudRst),
    .busy_o     (busy),
    .locked_o   (locked),
    .err_o      (err)
  );

  // 10 MHz clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #20ms;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference outcome of a low pulse of lowLen cycles, straight from the
  // bit-period rules: returns {err, code}.
  function automatic logic [2:0] expectOutcome(input int lowLen);
    int p4800;
    int p9600;
    int p57600;
    int p115200;
    p4800   = CLK_FREQ / 4800;
    p9600   = CLK_FREQ / 9600;
    p57600  = CLK_FREQ / 57600;
    p115200 = CLK_FREQ / 115200;
    if (lowLen < p115200 / 2 || lowLen >= 2 * p4800) return 3'b100;
    if (lowLen >= (p4800 + p9600) / 2) return 3'b000;
    if (lowLen >= (p9600 + p57600) / 2) return 3'b001;
    if (lowLen >= (p57600 + p115200) / 2) return 3'b010;
    return 3'b011;
  endfunction

  task automatic applyStimulus(input logic st, input logic wr,
                               input logic [1:0] sel);
    startPulse = st;
    cfgWr      = wr;
    cfgSel     = sel;
    @(negedge clk);
    startPulse = 1'b0;
    cfgWr      = 1'b0;
  endtask

  // Follows one rate change from APPLY entry to lock. Optionally fires
  // start and cfg_wr in the middle of APPLY, which must be ignored.
  task automatic checkApply(input logic [1:0] expSel, input string tag,
                            input bit poke);
    int waited;
    int high;
    waited = 0;
    high   = 0;
    while (baudRst !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_rstSeen"}, baudRst, 1'b1);
    checkOutput({tag, "_sel"}, selBaud, expSel);
    checkOutput({tag, "_lockedLow"}, locked, 1'b0);
    while (baudRst === 1'b1 && high < 20) begin
      high++;
      if (poke && high == 2) begin
        startPulse = 1'b1;
        cfgWr      = 1'b1;
        cfgSel     = ~expSel;
      end
      @(negedge clk);
      startPulse = 1'b0;
      cfgWr      = 1'b0;
    end
    checkOutput({tag, "_rstLen"}, high, RST_CYCLES);
    checkOutput({tag, "_selHeld"}, selBaud, expSel);
    checkOutput({tag, "_lockedAtDrop"}, locked, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_locked"}, locked, 1'b1);
    checkOutput({tag, "_busyDone"}, busy, 1'b0);
    checkOutput({tag, "_rstOff"}, baudRst, 1'b0);
    checkOutput({tag, "_errClear"}, err, 1'b0);
    modelSel = expSel;
  endtask

  // Start detection and present a single low pulse of lowLen cycles.
  task automatic runDetect(input int lowLen, input string tag);
    logic [2:0] outcome;
    int         waited;
    outcome = expectOutcome(lowLen);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    checkOutput({tag, "_lockDrop"}, locked, 1'b0);
    checkOutput({tag, "_errCleared"}, err, 1'b0);
    repeat (3) @(negedge clk);
    rxLine = 1'b0;
    repeat (lowLen) @(negedge clk);
    rxLine = 1'b1;
    if (outcome[2]) begin
      waited = 0;
      while (busy !== 1'b0 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checkOutput({tag, "_idle"}, busy, 1'b0);
      checkOutput({tag, "_err"}, err, 1'b1);
      checkOutput({tag, "_selKept"}, selBaud, modelSel);
      checkOutput({tag, "_notLocked"}, locked, 1'b0);
      checkOutput({tag, "_noRst"}, baudRst, 1'b0);
    end else begin
      checkApply(outcome[1:0], tag, 1'b0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lens[$];
    int len;
    assertCount = 0;
    failCount   = 0;
    modelSel    = 2'b01;
    rst         = 1'b1;
    rxLine      = 1'b1;
    startPulse  = 1'b0;
    cfgWr       = 1'b0;
    cfgSel      = 2'b00;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_sel", selBaud, 2'b01);
    checkOutput("rst_locked", locked, 1'b0);
    checkOutput("rst_baudRst", baudRst, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("postRst_busy", busy, 1'b0);

    // Nominal rates, then a glitch.
    runDetect(1041, "det9600");
    runDetect(86, "det115200");
    runDetect(2083, "det4800");
    runDetect(30, "glitch");

    // start and cfg_wr together: manual path wins and clears err.
    applyStimulus(1'b1, 1'b1, 2'b11);
    checkApply(2'b11, "collide", 1'b1);
    repeat (3) @(negedge clk);

    // Threshold boundaries.
    lens = '{42, 43, 128, 129, 606, 607, 1561, 1562, 4165, 4166};
    foreach (lens[i]) runDetect(lens[i], $sformatf("edge%0d", lens[i]));

    // Random widths across the whole valid range.
    for (int i = 0; i < 6; i++) begin
      len = int'($urandom_range(20, 4200));
      runDetect(len, $sformatf("rand%0d", len));
    end

    // Long low: timeout while the line is still low.
    applyStimulus(1'b1, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    rxLine = 1'b0;
    repeat (4150) @(negedge clk);
    checkOutput("tmo_busyBefore", busy, 1'b1);
    checkOutput("tmo_errBefore", err, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("tmo_busyAfter", busy, 1'b0);
    checkOutput("tmo_errAfter", err, 1'b1);
    repeat (5000 - 4180) @(negedge clk);
    rxLine = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("tmo_errSticky", err, 1'b1);
    checkOutput("tmo_sel", selBaud, modelSel);
    checkOutput("tmo_locked", locked, 1'b0);

    // Manual write aborts a measurement in progress.
    applyStimulus(1'b1, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    rxLine = 1'b0;
    repeat (500) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 2'b10);
    checkApply(2'b10, "abort", 1'b0);
    rxLine = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during the second cycle of APPLY.
    applyStimulus(1'b1, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    rxLine = 1'b0;
    repeat (86) @(negedge clk);
    rxLine = 1'b1;
    for (int w = 0; w < 20 && baudRst !== 1'b1; w++) @(negedge clk);
    checkOutput("midRst_applyEntered", baudRst, 1'b1);
    @(negedge clk);
    #10;
    rst = 1'b1;
    #5;
    checkOutput("midRst_baudRst", baudRst, 1'b0);
    checkOutput("midRst_sel", selBaud, 2'b01);
    checkOutput("midRst_busy", busy, 1'b0);
    checkOutput("midRst_locked", locked, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    modelSel = 2'b01;
    repeat (3) @(negedge clk);
    len = int'($urandom_range(200, 2000));
    runDetect(len, "afterRst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
Configuration controller for the UART baud generators (Tx and Rx). It measures the start-bit width of a sync character on the serial line, or accepts a manual setting, and drives the 2-bit baud-select code shared by both generators. Each rate change is applied atomically: the generators are held in reset for a fixed number of cycles while the select code changes, so no runt baud-clock edges reach the datapath. It sits between the host config interface, the rx pin and the baud generators.

Parameters:
CLK_FREQ, 10_000_000, system clock frequency in Hz.
DEFAULT_SEL, 2'b01, select code loaded at reset (9600 baud).
RST_CYCLES, 4, number of cycles baud_rst is held high on each rate change (1..15).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
rx  in  1  raw serial line, asynchronous to clk, idle high.
start  in  1  single-cycle pulse that begins auto-baud detection.
cfg_wr  in  1  single-cycle manual select write.
cfg_sel  in  2  manual select code, valid when cfg_wr=1.
sel_baud  out  2  select code to the generators: 00=4800, 01=9600, 10=57600, 11=115200.
baud_rst  out  1  synchronous reset to the baud generators during a change.
busy  out  1  high in any state other than IDLE.
locked  out  1  high once a rate has been applied; low during detect and apply.
err  out  1  sticky detection-failure flag; cleared by start or cfg_wr.

Behaviour:
- Reset values: sel_baud=DEFAULT_SEL, baud_rst=0, busy=0, locked=0, err=0, FSM in IDLE, counters 0.
- Synchronisation: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s, which lags rx by 2 cycles.
- Bit period in cycles: P(b) = CLK_FREQ/b. At 10 MHz: P4800=2083, P9600=1041, P57600=173, P115200=86 (integer division).
- Classification thresholds on the measured low count N:
  - T0 = (P4800+P9600)/2
  - T1 = (P9600+P57600)/2
  - T2 = (P57600+P115200)/2
  - NMIN = P115200/2
  - NMAX = 2*P4800
  - All thresholds are localparams computed from CLK_FREQ.
  - Counter width is $clog2(NMAX+1).
- FSM states: IDLE, ARM, WAIT_FALL, MEASURE, APPLY.
- IDLE:
  - start moves to ARM and clears err.
  - cfg_wr latches cfg_sel as the pending code, clears err, and moves to APPLY.
- ARM: waits for rx_s=1 so detection never starts mid-frame, then moves to WAIT_FALL.
- WAIT_FALL: when rx_s=0, load N=1 and move to MEASURE. There is no timeout in this state.
- MEASURE:
  - While rx_s=0, N increments by 1 per cycle.
  - On rx_s=1, classify:
    - N<NMIN: err=1, go to IDLE, sel_baud unchanged.
    - N>=T0 gives 00; N>=T1 gives 01; N>=T2 gives 10; otherwise 11. Store the result as the pending code and go to APPLY.
  - If N reaches NMAX while rx_s is still 0: err=1, go to IDLE (timeout).
- APPLY:
  - On entry, sel_baud takes the pending code, baud_rst=1 and locked=0.
  - baud_rst stays high for exactly RST_CYCLES cycles.
  - On the cycle after it drops: locked=1, go to IDLE.
- locked drops on the cycle the FSM leaves IDLE via start. It stays high through a cfg_wr until APPLY entry.
- Simultaneous events and priority:
  - cfg_wr has priority over start in the same cycle.
  - cfg_wr in ARM, WAIT_FALL or MEASURE aborts detection and goes to APPLY with cfg_sel.
  - start and cfg_wr during APPLY are ignored.
- Reset mid-operation (any state, including APPLY): all outputs return to their reset values immediately, and baud_rst=0 asynchronously.
- The host must send a sync character whose bit0 is 1 (for example 0x55), so that the first low pulse is exactly one start bit.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] baud_sel_t (BRD4800, BRD9600, BRD57600, BRD115200), shared with the baud generators.
  - typedef enum for the FSM states.
  - function bit_period(clk_freq, baud), used to derive the thresholds.
- One sub-module, sync_2ff: a generic 2-flop synchroniser with a reset value parameter, instantiated for rx with reset value 1.

Test Plan:
All scenarios run at CLK_FREQ = 10 MHz.
1. Reset -> sel_baud=01, locked=0, baud_rst=0, busy=0.
2. Pulse start, then drive rx low for 1041 cycles -> sel_baud=01, baud_rst high for exactly 4 cycles, then locked=1. Repeat with a low time of 86 cycles -> 11, and 2083 cycles -> 00.
3. Pulse start, then a 30-cycle low glitch -> err=1, sel_baud unchanged, locked=0, FSM back in IDLE.
4. Pulse start, then hold rx low for 5000 cycles -> err=1 when N reaches 4166, FSM in IDLE.
5. Pulse start; after 500 low cycles, cfg_wr with cfg_sel=10 -> detection aborted, sel_baud=10, 4-cycle baud_rst, locked=1. Also: start and cfg_wr in the same cycle -> manual path taken.
6. Assert rst during cycle 2 of APPLY -> baud_rst=0 and sel_baud=01 immediately; a later detection completes normally.
